// File: rtl/alu8_acc_seq_pkg.sv
// Shared definitions for the accumulator sequencer and its ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu8_acc_seq_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

    // Only the two shift ops honour the repeat count.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu8_acc_seq_if.sv
// Command and result ports of the accumulator sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd side via cmd_ready, result side via res_ready.
interface alu8_acc_seq_if;
    import alu8_acc_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             flag_z;
    logic             busy;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_data, cmd_cnt, res_ready,
        input  cmd_ready, res_valid, res_data, flag_c, flag_v, flag_n, flag_z, busy
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_data, cmd_cnt, res_ready,
        output cmd_ready, res_valid, res_data, flag_c, flag_v, flag_n, flag_z, busy
    );

endinterface

// File: rtl/alu8_acc_seq_alu8.sv
// Combinational 8-bit ALU: add/sub/logic/not/single-bit shifts.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu8
    import alu8_acc_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ov,
    output logic             sign
);

    logic [WIDTH:0] sum9;
    logic [WIDTH:0] diff9;

    // Result and carry/overflow selection per opcode; logic ops clear C and V.
    always_comb begin
        sum9  = {1'b0, a} + {1'b0, b};
        diff9 = {1'b0, a} - {1'b0, b};
        z     = '0;
        cout  = 1'b0;
        ov    = 1'b0;
        case (op)
            OP_ADD: begin
                z    = sum9[WIDTH-1:0];
                cout = sum9[WIDTH];
                ov   = (a[WIDTH-1] == b[WIDTH-1]) && (sum9[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                z    = diff9[WIDTH-1:0];
                cout = diff9[WIDTH];
                ov   = (a[WIDTH-1] != b[WIDTH-1]) && (diff9[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_XOR:  z = a ^ b;
            OP_NOT:  z = ~a;
            OP_SHR:  z = a >> 1;
            OP_SHL:  z = a << 1;
            default: z = '0;
        endcase
    end

    assign sign = z[WIDTH-1];

endmodule

// File: rtl/alu8_acc_seq.sv
// Accumulator command sequencer feeding alu8 and writing its result back.
// Latency: load 1 cycle, ALU op 2 cycles, shift with count k takes k+2 cycles to res_valid.
// Backpressure: result held in HOLD until res_ready; cmd_ready only asserted in IDLE.
module alu8_acc_seq
    import alu8_acc_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu8_acc_seq_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] iter;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] b_q;
    flags_t           flags;
    logic             cmd_ready;
    logic             res_valid;
    logic             busy;

    logic [WIDTH-1:0] alu_z;
    logic             alu_cout;
    logic             alu_ov;

    alu8 u_alu (
        .a    (acc),
        .b    (b_q),
        .op   (op_q),
        .z    (alu_z),
        .cout (alu_cout),
        .ov   (alu_ov),
        .sign ()
    );

    // Sequencer FSM: accept, iterate the ALU into acc, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            iter      <= '0;
            op_q      <= OP_ADD;
            b_q       <= '0;
            flags     <= '{c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b1};
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (bus.cmd_load) begin
                            acc       <= bus.cmd_data;
                            flags     <= '{c: 1'b0, v: 1'b0,
                                           n: bus.cmd_data[WIDTH-1],
                                           z: (bus.cmd_data == '0)};
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            op_q  <= bus.cmd_op;
                            b_q   <= bus.cmd_data;
                            iter  <= is_shift(bus.cmd_op) ? bus.cmd_cnt : '0;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc <= alu_z;
                    // Flags reflect only the final iteration of a repeated shift.
                    if (iter == '0) begin
                        flags     <= '{c: alu_cout, v: alu_ov,
                                       n: alu_z[WIDTH-1], z: (alu_z == '0)};
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        iter <= iter - 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = acc;
    assign bus.flag_c    = flags.c;
    assign bus.flag_v    = flags.v;
    assign bus.flag_n    = flags.n;
    assign bus.flag_z    = flags.z;
    assign bus.busy      = busy;

endmodule
